mask_splitter32: RTL and testbench



---
 rtl/mask_splitter32.sv | 111 +++++++++++
 tb/tb_mask_splitter32.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_splitter32.sv
// Splits a 32-bit mask into a stream of set-bit indices, one per valid/ready handshake.
// Define MASK_SPLIT_MSB_FIRST_EN to emit the highest set bit first instead of the lowest.
module mask_splitter32 #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic [WIDTH-1:0] out_bit,
   output logic             out_last,
   output logic [IDXW:0]    out_cnt,
   output logic             busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] REM_ONE = WIDTH'(1);
   localparam logic [IDXW:0]    CNT_ONE = (IDXW+1)'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [IDXW:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] sel;
   logic [IDXW-1:0]  sel_idx;
   logic             sel_last;
   logic             emit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MASK_SPLIT_MSB_FIRST_EN
   // Later (higher) set bits overwrite earlier ones, leaving only the highest.
   always_comb begin
      sel = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (rem_q[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
   end
`else
   assign sel = rem_q & (~rem_q + REM_ONE);
`endif

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sel[i]) sel_idx = IDXW'(i);
      end
   end

   assign sel_last = ((rem_q & (rem_q - REM_ONE)) == '0);
   assign emit     = (state_q == ST_EMIT);

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cnt_d = '0;
               if (in_mask != '0) begin
                  rem_d   = in_mask;
                  state_d = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               rem_d = rem_q & ~sel;
               cnt_d = cnt_q + CNT_ONE;
               if (sel_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign out_bit  = emit ? sel : '0;
   assign out_idx  = emit ? sel_idx : '0;
   assign out_last = emit && sel_last;
   assign out_cnt  = cnt_q;

endmodule

// File: tb/tb_mask_splitter32.sv
// Self-checking bench for mask_splitter32: directed scenarios plus random masks against a queue model.
// Honours MASK_SPLIT_MSB_FIRST_EN to expect descending index order.
module tb_mask_splitter32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_mask;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic [31:0] out_bit;
   logic        out_last;
   logic [5:0]  out_cnt;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   int exp_q[$];
   int log_q[$];
   int mdl_cnt = 0;

   mask_splitter32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mask   (in_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_bit   (out_bit),
      .out_last  (out_last),
      .out_cnt   (out_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   function automatic void load_model(input logic [31:0] m);
      exp_q.delete();
`ifdef MASK_SPLIT_MSB_FIRST_EN
      for (int i = 31; i >= 0; i--) if (m[i]) exp_q.push_back(i);
`else
      for (int i = 0; i < 32; i++) if (m[i]) exp_q.push_back(i);
`endif
   endfunction

   // Reference model: a queue of pending indices plus a handoff counter.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         mdl_cnt = 0;
      end else if (exp_q.size() > 0) begin
         if (out_ready) begin
            log_q.push_back(exp_q.pop_front());
            mdl_cnt = mdl_cnt + 1;
         end
      end else if (in_valid) begin
         mdl_cnt = 0;
         load_model(in_mask);
      end
   end

   always @(negedge clk) begin
      automatic bit v = (exp_q.size() > 0);
      check("out_valid", 32'(out_valid), 32'(v));
      check("in_ready", 32'(in_ready), 32'(!v));
      check("busy", 32'(busy), 32'(v));
      check("out_cnt", 32'(out_cnt), 32'(mdl_cnt));
      if (v) begin
         check("out_idx", 32'(out_idx), 32'(exp_q[0]));
         check("out_bit", out_bit, 32'(1) << exp_q[0]);
         check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
      end
      if (rst) begin
         check("rst_idx", 32'(out_idx), 32'd0);
         check("rst_bit", out_bit, 32'd0);
         check("rst_last", 32'(out_last), 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] m);
      in_valid = 1'b1;
      in_mask  = m;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      if (exp_q.size() > 0) check("timeout", 32'd1, 32'd0);
   endtask

   task automatic check_log(input string tag, input int exp_seq[$]);
      check({tag, "_len"}, 32'(log_q.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < log_q.size(); i++)
         check({tag, "_seq"}, 32'(log_q[i]), 32'(exp_seq[i]));
   endtask

   initial begin
      int seq[$];
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mask   = '0;
      out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // zero mask: consumed, nothing emitted
      out_ready = 1'b1;
      send(32'h0);
      check("zero_ready", 32'(in_ready), 32'd1);
      check("zero_valid", 32'(out_valid), 32'd0);
      check("zero_cnt", 32'(out_cnt), 32'd0);
      step();

      log_q.delete();
      send(32'h8000_0011);
      wait_done(10);
`ifdef MASK_SPLIT_MSB_FIRST_EN
      seq = '{31, 4, 0};
`else
      seq = '{0, 4, 31};
`endif
      check_log("m80000011", seq);
      check("m80000011_cnt", 32'(out_cnt), 32'd3);
      check("m80000011_rdy", 32'(in_ready), 32'd1);

      // backpressure holds the head index steady
      log_q.delete();
      out_ready = 1'b0;
      send(32'h0000_000C);
      repeat (3) begin
`ifdef MASK_SPLIT_MSB_FIRST_EN
         check("hold_idx", 32'(out_idx), 32'd3);
         check("hold_bit", out_bit, 32'h8);
`else
         check("hold_idx", 32'(out_idx), 32'd2);
         check("hold_bit", out_bit, 32'h4);
`endif
         step();
      end
      out_ready = 1'b1;
      wait_done(10);
`ifdef MASK_SPLIT_MSB_FIRST_EN
      seq = '{3, 2};
`else
      seq = '{2, 3};
`endif
      check_log("m0000000C", seq);

      // full mask; a second mask offered during EMIT must wait
      log_q.delete();
      send(32'hFFFF_FFFF);
      in_valid = 1'b1;
      in_mask  = 32'h5;
      repeat (10) begin
         check("full_no_accept", 32'(in_ready), 32'd0);
         step();
      end
      in_valid = 1'b0;
      wait_done(40);
      check("full_cnt", 32'(out_cnt), 32'd32);
      check("full_len", 32'(log_q.size()), 32'd32);

      // reset in the middle of splitting
      log_q.delete();
      send(32'h0000_00F0);
      step();
      step();
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_cnt", 32'(out_cnt), 32'd0);
      step();
      rst = 1'b0;
      step();
      log_q.delete();
      send(32'h1);
      check("one_last", 32'(out_last), 32'd1);
      wait_done(5);
      seq = '{0};
      check_log("m00000001", seq);
      check("one_cnt", 32'(out_cnt), 32'd1);

      // random masks with random backpressure and offer timing
      for (int t = 0; t < 60; t++) begin
         logic [31:0] m;
         int budget;
         case ($urandom_range(0, 3))
            0: m = $urandom;
            1: m = $urandom & $urandom & $urandom;
            2: m = 32'(1) << $urandom_range(0, 31);
            default: m = ($urandom_range(0, 4) == 0) ? 32'h0 : ~(32'(1) << $urandom_range(0, 31));
         endcase
         in_valid = 1'b1;
         in_mask  = m;
         out_ready = 1'($urandom_range(0, 1));
         step();
         in_valid = 1'b0;
         budget = 0;
         while (exp_q.size() > 0 && budget < 400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
               in_valid = 1'b1;
               in_mask  = $urandom;
            end else begin
               in_valid = 1'b0;
            end
            step();
            budget++;
         end
         in_valid = 1'b0;
         if (exp_q.size() > 0) check("rand_timeout", 32'd1, 32'd0);
         wait_done(100);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
